// File: rtl/ct_lsu_lq_create_ctrl_pkg.sv
// Shared LSU load-queue definitions: sizing defaults, DA result bundle and
// the saturating full-counter helper.
package ct_lsu_lq_create_ctrl_pkg;

   localparam int unsigned LQ_ENTRY_DFLT     = 16;
   localparam int unsigned IID_W             = 7;
   localparam int unsigned STALL_THRESH_DFLT = 4;
   localparam int unsigned FULL_CNT_W        = 3;

   localparam logic [FULL_CNT_W-1:0] FULL_CNT_MAX = '1;

   // Results registered from DC into DA
   typedef struct packed {
      logic full;
      logic rar;
      logic raw;
      logic stall;
      logic empty;
   } lq_da_res_t;

   function automatic logic [FULL_CNT_W-1:0] full_cnt_inc(input logic [FULL_CNT_W-1:0] cnt);
      return (cnt == FULL_CNT_MAX) ? cnt : cnt + FULL_CNT_W'(1);
   endfunction

endpackage

// File: rtl/ct_lsu_lq_create_ctrl_find_free.sv
// Priority search over a free vector: one-hot lowest and second-lowest set
// bits plus "at least one" / "at least two" flags.
module ct_lsu_lq_find_free
   import ct_lsu_lq_create_ctrl_pkg::*;
#(
   parameter int unsigned LQ_ENTRY = LQ_ENTRY_DFLT
) (
   input  logic [LQ_ENTRY-1:0] free_vec,
   output logic [LQ_ENTRY-1:0] first_oh,
   output logic [LQ_ENTRY-1:0] second_oh,
   output logic                cnt_ge1,
   output logic                cnt_ge2
);

   logic [LQ_ENTRY-1:0] rest_vec;

   // x & -x isolates the lowest set bit; repeat on the remainder for the second
   always_comb begin
      first_oh  = free_vec & (~free_vec + LQ_ENTRY'(1));
      rest_vec  = free_vec & ~first_oh;
      second_oh = rest_vec & (~rest_vec + LQ_ENTRY'(1));
      cnt_ge1   = |free_vec;
      cnt_ge2   = |rest_vec;
   end

endmodule

// File: rtl/ct_lsu_lq_create_ctrl.sv
// Load-queue entry allocation for a load and its cross-line second half,
// plus DA-stage reduction of speculation fails and full-replay stall tracking.
module ct_lsu_lq_create_ctrl
   import ct_lsu_lq_create_ctrl_pkg::*;
#(
   parameter int unsigned LQ_ENTRY     = LQ_ENTRY_DFLT,
   parameter int unsigned STALL_THRESH = STALL_THRESH_DFLT
) (
   input  logic                forever_cpuclk,
   input  logic                cpurst,
   input  logic                ld_dc_inst_chk_vld,
   input  logic                ld_dc_chk_ld_addr1_vld,
   input  logic [LQ_ENTRY-1:0] lq_entry_vld_x,
   input  logic [LQ_ENTRY-1:0] lq_entry_inst_hit_x,
   input  logic [LQ_ENTRY-1:0] lq_entry_rar_spec_fail_x,
   input  logic [LQ_ENTRY-1:0] lq_entry_raw_spec_fail_x,
   input  logic                rtu_yy_xx_flush,
   output logic [LQ_ENTRY-1:0] lq_entry_create0_vld_x,
   output logic [LQ_ENTRY-1:0] lq_entry_create0_dp_vld_x,
   output logic [LQ_ENTRY-1:0] lq_entry_create_gateclk_en_x,
   output logic [LQ_ENTRY-1:0] lq_entry_create1_vld_x,
   output logic [LQ_ENTRY-1:0] lq_entry_create1_dp_vld_x,
   output logic [LQ_ENTRY-1:0] lq_entry_create1_gateclk_en_x,
   output logic                lq_ld_da_full,
   output logic                lq_ld_da_rar_spec_fail,
   output logic                lq_st_da_raw_spec_fail,
   output logic                lq_full_stall_req,
   output logic                lq_empty
);

   logic [LQ_ENTRY-1:0]   free_vec;
   logic [LQ_ENTRY-1:0]   ptr0_oh;
   logic [LQ_ENTRY-1:0]   ptr1_oh;
   logic                  free_ge1;
   logic                  free_ge2;

   logic                  req0;
   logic                  req1;
   logic                  dup_hit;
   logic                  enough;
   logic                  alloc0;
   logic                  alloc1;
   logic                  full_dc;

   logic [FULL_CNT_W-1:0] full_cnt_q;
   logic [FULL_CNT_W-1:0] full_cnt_nxt;
   lq_da_res_t            da_q;
   lq_da_res_t            da_nxt;

   assign free_vec = ~lq_entry_vld_x;

   ct_lsu_lq_find_free #(
      .LQ_ENTRY (LQ_ENTRY)
   ) u_find_free (
      .free_vec  (free_vec),
      .first_oh  (ptr0_oh),
      .second_oh (ptr1_oh),
      .cnt_ge1   (free_ge1),
      .cnt_ge2   (free_ge2)
   );

   // Allocation decision: all-or-nothing, duplicates never allocate nor refuse
   always_comb begin
      req0    = ld_dc_inst_chk_vld;
      req1    = req0 & ld_dc_chk_ld_addr1_vld;
      dup_hit = |lq_entry_inst_hit_x;
      enough  = req1 ? free_ge2 : free_ge1;
      alloc0  = req0 & ~dup_hit & enough;
      alloc1  = alloc0 & req1;
      full_dc = req0 & ~dup_hit & ~enough;
   end

   // DC create strobes; only the valid strobe is killed by flush
   always_comb begin
      lq_entry_create0_dp_vld_x     = alloc0 ? ptr0_oh : '0;
      lq_entry_create1_dp_vld_x     = alloc1 ? ptr1_oh : '0;
      lq_entry_create_gateclk_en_x  = lq_entry_create0_dp_vld_x;
      lq_entry_create1_gateclk_en_x = lq_entry_create1_dp_vld_x;
      lq_entry_create0_vld_x        = rtu_yy_xx_flush ? '0 : lq_entry_create0_dp_vld_x;
      lq_entry_create1_vld_x        = rtu_yy_xx_flush ? '0 : lq_entry_create1_dp_vld_x;
   end

   // Next-state: flush clears, refusal counts, any satisfied request clears
   always_comb begin
      full_cnt_nxt = full_cnt_q;
      da_nxt       = '0;
      if (rtu_yy_xx_flush) begin
         full_cnt_nxt = '0;
      end else if (full_dc) begin
         full_cnt_nxt = full_cnt_inc(full_cnt_q);
      end else if (req0) begin
         full_cnt_nxt = '0;
      end
      da_nxt.full  = full_dc & ~rtu_yy_xx_flush;
      da_nxt.rar   = (|lq_entry_rar_spec_fail_x) & ~rtu_yy_xx_flush;
      da_nxt.raw   = (|lq_entry_raw_spec_fail_x) & ~rtu_yy_xx_flush;
      da_nxt.stall = (full_cnt_nxt >= FULL_CNT_W'(STALL_THRESH));
      da_nxt.empty = ~|lq_entry_vld_x;
   end

   always_ff @(posedge forever_cpuclk) begin
      if (cpurst) begin
         full_cnt_q <= '0;
         da_q       <= '0;
      end else begin
         full_cnt_q <= full_cnt_nxt;
         da_q       <= da_nxt;
      end
   end

   assign lq_ld_da_full          = da_q.full;
   assign lq_ld_da_rar_spec_fail = da_q.rar;
   assign lq_st_da_raw_spec_fail = da_q.raw;
   assign lq_full_stall_req      = da_q.stall;
   assign lq_empty               = da_q.empty;

endmodule

// File: tb/tb_ct_lsu_lq_create_ctrl.sv
// Scoreboard bench for ct_lsu_lq_create_ctrl: directed cases then random
// traffic, predicted by an index-loop reference model.
module tb_ct_lsu_lq_create_ctrl;

   localparam int unsigned N  = 16;
   localparam int unsigned TH = 4;

   logic          clk = 1'b0;
   logic          rst;
   logic          req0_i, req1_i, flush_i;
   logic [N-1:0]  vld_i, hit_i, rar_i, raw_i;
   logic [N-1:0]  c0v, c0d, c0g, c1v, c1d, c1g;
   logic          da_full, da_rar, da_raw, stall, empty;

   ct_lsu_lq_create_ctrl #(.LQ_ENTRY(N), .STALL_THRESH(TH)) dut (
      .forever_cpuclk                (clk),
      .cpurst                        (rst),
      .ld_dc_inst_chk_vld            (req0_i),
      .ld_dc_chk_ld_addr1_vld        (req1_i),
      .lq_entry_vld_x                (vld_i),
      .lq_entry_inst_hit_x           (hit_i),
      .lq_entry_rar_spec_fail_x      (rar_i),
      .lq_entry_raw_spec_fail_x      (raw_i),
      .rtu_yy_xx_flush               (flush_i),
      .lq_entry_create0_vld_x        (c0v),
      .lq_entry_create0_dp_vld_x     (c0d),
      .lq_entry_create_gateclk_en_x  (c0g),
      .lq_entry_create1_vld_x        (c1v),
      .lq_entry_create1_dp_vld_x     (c1d),
      .lq_entry_create1_gateclk_en_x (c1g),
      .lq_ld_da_full                 (da_full),
      .lq_ld_da_rar_spec_fail        (da_rar),
      .lq_st_da_raw_spec_fail        (da_raw),
      .lq_full_stall_req             (stall),
      .lq_empty                      (empty)
   );

   always #5 clk = ~clk;

   typedef struct {
      int           due;
      logic [N-1:0] v0, d0, v1, d1;
   } strb_exp_t;

   typedef struct {
      int   due;
      logic full, rar, raw, stall, empty;
   } da_exp_t;

   strb_exp_t strb_q[$];
   da_exp_t   da_q[$];
   int        cyc = 0;
   int        checks = 0;
   int        errors = 0;
   int        m_cnt = 0;
   logic      done = 1'b0;

   always @(posedge clk) cyc <= cyc + 1;

   // Drive one DC cycle and predict its strobes (now) and DA results (next cycle)
   task automatic drive(input logic r, input logic fl, input logic q0, input logic q1,
                        input logic [N-1:0] vld, input logic [N-1:0] hit,
                        input logic [N-1:0] rar, input logic [N-1:0] raw);
      int        p0, p1;
      logic      dup, enough, alloc, full;
      strb_exp_t se;
      da_exp_t   de;
      @(posedge clk);
      #1;
      rst = r; flush_i = fl; req0_i = q0; req1_i = q1;
      vld_i = vld; hit_i = hit; rar_i = rar; raw_i = raw;
      p0 = -1; p1 = -1;
      for (int i = 0; i < int'(N); i++) begin
         if (!vld[i]) begin
            if (p0 < 0) p0 = i;
            else if (p1 < 0) p1 = i;
         end
      end
      dup    = (hit != 0);
      enough = (q0 && q1) ? (p1 >= 0) : (p0 >= 0);
      alloc  = q0 && !dup && enough;
      full   = q0 && !dup && !enough;
      se.due = cyc;
      se.d0  = alloc ? (N'(1) << p0) : '0;
      se.d1  = (alloc && q1) ? (N'(1) << p1) : '0;
      se.v0  = fl ? '0 : se.d0;
      se.v1  = fl ? '0 : se.d1;
      strb_q.push_back(se);
      if (r || fl) m_cnt = 0;
      else if (full) m_cnt = (m_cnt + 1 > 7) ? 7 : m_cnt + 1;
      else if (q0) m_cnt = 0;
      de.due   = cyc + 1;
      de.full  = !r && full && !fl;
      de.rar   = !r && (rar != 0) && !fl;
      de.raw   = !r && (raw != 0) && !fl;
      de.stall = !r && (m_cnt >= int'(TH));
      de.empty = !r && (vld == 0);
      da_q.push_back(de);
   endtask

   function automatic void chk(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s cyc=%0d actual=%h required=%h", name, cyc, act, exp);
      end
   endfunction

   // Monitor: compare whatever the DUT presents against the scoreboard queues
   always @(negedge clk) begin
      while (da_q.size() > 0 && da_q[0].due <= cyc) begin
         da_exp_t e;
         e = da_q.pop_front();
         chk("da_full",  N'(da_full), N'(e.full));
         chk("da_rar",   N'(da_rar),  N'(e.rar));
         chk("da_raw",   N'(da_raw),  N'(e.raw));
         chk("stall",    N'(stall),   N'(e.stall));
         chk("empty",    N'(empty),   N'(e.empty));
      end
      while (strb_q.size() > 0 && strb_q[0].due <= cyc) begin
         strb_exp_t s;
         s = strb_q.pop_front();
         chk("create0_vld", c0v, s.v0);
         chk("create0_dp",  c0d, s.d0);
         chk("create0_gce", c0g, s.d0);
         chk("create1_vld", c1v, s.v1);
         chk("create1_dp",  c1d, s.d1);
         chk("create1_gce", c1g, s.d1);
      end
      if (done) begin
         checks++;
         if (strb_q.size() + da_q.size() != 0) begin
            errors++;
            $display("FAIL drain actual=%0d required=0 pending", strb_q.size() + da_q.size());
         end
         $display("Result: errors=%0d of %0d checks", errors, checks);
         $finish;
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [N-1:0] v, h, ra, rw;
      rst = 1'b1; flush_i = 1'b0; req0_i = 1'b0; req1_i = 1'b0;
      vld_i = '0; hit_i = '0; rar_i = '0; raw_i = '0;
      drive(1, 0, 0, 0, '0, '0, '0, '0);
      drive(1, 0, 0, 0, '0, '0, '0, '0);
      drive(0, 0, 1, 0, 16'h0000, '0, '0, '0);
      drive(0, 0, 1, 1, 16'hFFF3, '0, '0, '0);
      drive(0, 0, 1, 1, 16'hFFFB, '0, '0, '0);
      drive(0, 0, 1, 1, 16'h3FFF, '0, '0, '0);
      drive(0, 1, 0, 0, 16'hFFFF, '0, '0, '0);
      for (int i = 0; i < 5; i++) drive(0, 0, 1, 0, 16'hFFFF, '0, '0, '0);
      drive(0, 1, 1, 0, 16'hFFFF, '0, '0, '0);
      drive(0, 0, 1, 0, 16'hFFFF, '0, '0, '0);
      drive(0, 0, 1, 0, 16'h00FF, 16'h0010, '0, '0);
      drive(0, 1, 1, 0, 16'h00FF, '0, 16'h0200, 16'h8000);
      drive(0, 0, 1, 0, 16'h00FF, '0, 16'h0200, 16'h8000);
      for (int i = 0; i < 9; i++) drive(0, 0, 1, 0, 16'hFFFF, '0, '0, '0);
      drive(0, 0, 0, 0, 16'hFFFF, '0, '0, '0);
      drive(1, 0, 1, 0, 16'hFFFF, '0, '0, '0);
      for (int n = 0; n < 400; n++) begin
         case ($urandom_range(0, 3))
            0: v = 16'hFFFF;
            1: v = ~(N'(1) << $urandom_range(0, 15));
            2: v = N'($urandom) | N'($urandom);
            default: v = N'($urandom);
         endcase
         h  = ($urandom_range(0, 7) == 0) ? (N'(1) << $urandom_range(0, 15)) : '0;
         ra = ($urandom_range(0, 3) == 0) ? N'($urandom) : '0;
         rw = ($urandom_range(0, 3) == 0) ? N'($urandom) : '0;
         drive($urandom_range(0, 49) == 0, $urandom_range(0, 9) == 0,
               $urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, v, h, ra, rw);
      end
      @(posedge clk);
      @(posedge clk);
      #1 done = 1'b1;
   end

endmodule
